// File: rtl/uart_pkg.sv
// Shared constants, transmitter state type and BCD-to-ASCII helper for the
// BCD frame UART sender.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_DP   = 8'h2E;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4
  } tx_state_e;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    logic [7:0] ch;
    if (digit <= 4'd9) begin
      ch = ASCII_ZERO + {4'd0, digit};
    end else begin
      ch = ASCII_ERR;
    end
    return ch;
  endfunction

endpackage

// File: rtl/uart_char_tx.sv
// Serialises one byte as start, 8 data bits LSB first, optional even parity
// (UART_BCD_PARITY_EN) and STOP_BITS stop bits; tx_out is registered.
module uart_char_tx
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx_out
);

  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       tx_q, tx_d;
  logic       last_stop_s;

  // Ready also in the final stop cycle so the next character starts without a gap.
  assign last_stop_s = (state_q == STOP) && (stop_cnt_q == STOP_LAST);
  assign ready       = (state_q == IDLE) || last_stop_s;
  assign tx_out      = tx_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    byte_d     = byte_q;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (load) begin
          byte_d  = data;
          state_d = START_BIT;
        end else begin
          state_d = IDLE;
        end
      end
      START_BIT: begin
        bit_idx_d = 3'd0;
        state_d   = DATA;
      end
      DATA: begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
`ifdef UART_BCD_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
          stop_cnt_d = 1'b0;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        stop_cnt_d = 1'b0;
        state_d    = STOP;
      end
      STOP: begin
        if (last_stop_s) begin
          stop_cnt_d = 1'b0;
          if (load) begin
            byte_d  = data;
            state_d = START_BIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is decoded from the state being entered so tx_out is a flop.
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = byte_d[bit_idx_d];
      PARITY:    tx_d = ^byte_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      byte_q     <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      byte_q     <= byte_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: rtl/uart_bcd_frame_tx.sv
// Sends a snapshot of NUM_DIGITS BCD digits as ASCII with optional '.', then
// CR LF, over UART. Parity bit compiled in with UART_BCD_PARITY_EN.
module uart_bcd_frame_tx
  import uart_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DP_POS     = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic                    baud_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_digits,
  output logic                    tx_out,
  output logic                    busy,
  output logic                    done
);

  localparam int         NUM_CHARS = NUM_DIGITS + ((DP_POS > 0) ? 1 : 0) + 2;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_CHARS - 1);
  localparam logic [3:0] CR_IDX    = 4'(NUM_CHARS - 2);
  localparam logic [3:0] DP_IDX    = 4'(DP_POS);

  logic                    active_q, active_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [3:0]              char_idx_q, char_idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    load_s;
  logic                    char_ready_s;
  logic [7:0]              char_s;
  int                      digit_k;

  assign busy = busy_q;
  assign done = done_q;

  // Frame sequencer: accept a request while idle, advance on each character handoff.
  always_comb begin
    active_d   = active_q;
    char_idx_d = char_idx_q;
    snap_d     = snap_q;
    done_d     = 1'b0;
    load_s     = 1'b0;

    if (!active_q) begin
      if (start) begin
        active_d   = 1'b1;
        char_idx_d = 4'd0;
        snap_d     = bcd_digits;
        load_s     = 1'b1;
      end else begin
        active_d = 1'b0;
      end
    end else if (char_ready_s) begin
      if (char_idx_q < LAST_IDX) begin
        char_idx_d = char_idx_q + 4'd1;
        load_s     = 1'b1;
      end else begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end else begin
      active_d = 1'b1;
    end

    busy_d = active_d;
  end

  // Character mux works on the next-cycle index/snapshot so the byte is ready at load.
  always_comb begin
    char_s  = ASCII_LF;
    digit_k = 0;
    if ((DP_POS > 0) && (char_idx_d == DP_IDX)) begin
      char_s = ASCII_DP;
    end else if (char_idx_d == CR_IDX) begin
      char_s = ASCII_CR;
    end else if (char_idx_d == LAST_IDX) begin
      char_s = ASCII_LF;
    end else begin
      digit_k = ((DP_POS > 0) && (char_idx_d > DP_IDX)) ? (int'(char_idx_d) - 1) : int'(char_idx_d);
      char_s  = bcd_to_ascii(snap_d[4*(NUM_DIGITS-1-digit_k) +: 4]);
    end
  end

  // Sequencer registers.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      char_idx_q <= 4'd0;
      snap_q     <= '0;
    end else begin
      active_q   <= active_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      char_idx_q <= char_idx_d;
      snap_q     <= snap_d;
    end
  end

  uart_char_tx #(
    .STOP_BITS(STOP_BITS)
  ) u_char_tx (
    .clk   (baud_clk),
    .reset (reset),
    .load  (load_s),
    .data  (char_s),
    .ready (char_ready_s),
    .tx_out(tx_out)
  );

endmodule

// File: tb/tb_uart_bcd_frame_tx.sv
// Self-checking bench for uart_bcd_frame_tx: table vectors, corner sequences
// and random frames against a string-level frame model.
module tb_uart_bcd_frame_tx;

`ifdef UART_BCD_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] dig_a = 16'h0;
  logic [11:0] dig_b = 12'h0;
  logic        tx_a, busy_a, done_a;
  logic        tx_b, busy_b, done_b;

  int tests = 0;
  int fails = 0;

  typedef logic [7:0] byte_q_t[$];
  typedef logic       bit_q_t[$];

  typedef struct {
    logic [15:0] dig;
    int          mod_c;
    logic [15:0] new_dig;
    int          restart_c;
    logic [55:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  uart_bcd_frame_tx dut_a (
    .baud_clk  (clk),
    .reset     (reset),
    .start     (start_a),
    .bcd_digits(dig_a),
    .tx_out    (tx_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  uart_bcd_frame_tx #(.NUM_DIGITS(3), .DP_POS(0), .STOP_BITS(2)) dut_b (
    .baud_clk  (clk),
    .reset     (reset),
    .start     (start_b),
    .bcd_digits(dig_b),
    .tx_out    (tx_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the character string a frame should carry.
  function automatic byte_q_t chars_of(input logic [31:0] dig, input int nd, input int dp);
    byte_q_t q;
    int nib;
    for (int i = 0; i < nd; i++) begin
      if (dp > 0 && i == dp) q.push_back(8'h2E);
      nib = int'((dig >> (4 * (nd - 1 - i))) & 32'hF);
      q.push_back(nib < 10 ? 8'(48 + nib) : 8'h3F);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  function automatic byte_q_t bytes_from(input logic [55:0] e);
    byte_q_t q;
    for (int i = 0; i < 7; i++) q.push_back(e[55 - 8 * i -: 8]);
    return q;
  endfunction

  // Reference: the line level in every cycle of the frame.
  function automatic bit_q_t frame_bits(input byte_q_t cs, input int stop_bits);
    bit_q_t b;
    foreach (cs[i]) begin
      b.push_back(1'b0);
      for (int k = 0; k < 8; k++) b.push_back(cs[i][k]);
      if (P == 1) b.push_back(^cs[i]);
      for (int s = 0; s < stop_bits; s++) b.push_back(1'b1);
    end
    return b;
  endfunction

  // Called at the negedge where start was raised; checks the whole frame and the done cycle.
  task automatic watch(input int which, input bit_q_t bits, input bit hold, input int mod_c,
                       input logic [15:0] new_dig, input int restart_c, input string name);
    int bit_err = 0;
    int busy_err = 0;
    int done_err = 0;
    logic t, b, d;
    for (int c = 1; c <= bits.size(); c++) begin
      @(negedge clk);
      t = (which == 1) ? tx_b : tx_a;
      b = (which == 1) ? busy_b : busy_a;
      d = (which == 1) ? done_b : done_a;
      if (t !== bits[c-1]) bit_err++;
      if (b !== 1'b1) busy_err++;
      if (d !== 1'b0) done_err++;
      if (c == 1 && !hold) begin
        if (which == 1) start_b = 1'b0;
        else start_a = 1'b0;
      end
      if (which == 0 && c == mod_c) dig_a = new_dig;
      if (which == 0 && c == restart_c) start_a = 1'b1;
      if (which == 0 && c == restart_c + 1) start_a = 1'b0;
    end
    check({name, " bit_errors"}, bit_err, 0);
    check({name, " busy_low_cycles"}, busy_err, 0);
    check({name, " early_done_cycles"}, done_err, 0);
    @(negedge clk);
    t = (which == 1) ? tx_b : tx_a;
    b = (which == 1) ? busy_b : busy_a;
    d = (which == 1) ? done_b : done_a;
    check({name, " end_tx_busy_done"}, {61'd0, t, b, d}, 64'h5);
  endtask

  task automatic idle_check(input int which, input int n, input string name);
    int errs = 0;
    logic t, b, d;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      t = (which == 1) ? tx_b : tx_a;
      b = (which == 1) ? busy_b : busy_a;
      d = (which == 1) ? done_b : done_a;
      if (t !== 1'b1 || b !== 1'b0 || d !== 1'b0) errs++;
    end
    check({name, " idle_errors"}, errs, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t   vecs[5];
    bit_q_t bq;
    logic [31:0] r;

    vecs[0] = '{16'h1234, -1, 16'h0000, -1, 56'h312E3233340D0A};
    vecs[1] = '{16'h1234,  5, 16'h9999, 20, 56'h312E3233340D0A};
    vecs[2] = '{16'h0A05, -1, 16'h0000, -1, 56'h302E3F30350D0A};
    vecs[3] = '{16'h9999, -1, 16'h0000, -1, 56'h392E3939390D0A};
    vecs[4] = '{16'hF09B, -1, 16'h0000, -1, 56'h3F2E30393F0D0A};

    repeat (3) @(negedge clk);
    check("reset_a", {61'd0, tx_a, busy_a, done_a}, 64'h4);
    check("reset_b", {61'd0, tx_b, busy_b, done_b}, 64'h4);
    reset = 1'b0;
    idle_check(0, 3, "post_reset");

    for (int i = 0; i < 5; i++) begin
      dig_a   = vecs[i].dig;
      start_a = 1'b1;
      watch(0, frame_bits(bytes_from(vecs[i].exp), 1), 1'b0, vecs[i].mod_c,
            vecs[i].new_dig, vecs[i].restart_c, $sformatf("vec%0d", i));
      idle_check(0, 4, $sformatf("vec%0d_after", i));
    end

    // Reset in the middle of a frame.
    dig_a   = 16'h1234;
    start_a = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midreset_tx_busy_done", {61'd0, tx_a, busy_a, done_a}, 64'h4);
    reset = 1'b0;
    idle_check(0, 5, "midreset_after");
    dig_a   = 16'h5678;
    start_a = 1'b1;
    watch(0, frame_bits(chars_of(32'h5678, 4, 1), 1), 1'b0, -1, 16'h0, -1, "post_midreset");

    // Random digits with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r       = $urandom;
      dig_a   = r[15:0];
      start_a = 1'b1;
      watch(0, frame_bits(chars_of({16'd0, r[15:0]}, 4, 1), 1), 1'b0, -1, 16'h0, -1,
            $sformatf("rand%0d_%04h", i, r[15:0]));
    end

    // Start held high on the 3-digit, 2-stop-bit instance: back-to-back frames.
    bq      = frame_bits(chars_of(32'h907, 3, 0), 2);
    dig_b   = 12'h907;
    start_b = 1'b1;
    watch(1, bq, 1'b1, -1, 16'h0, -1, "held_f1");
    watch(1, bq, 1'b0, -1, 16'h0, -1, "held_f2");
    idle_check(1, 4, "held_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
